// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a shared BCD decoder.
// Double-buffered value, leading-zero blanking, active-low anode enables.
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        blank_lz,
    output logic        W,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic [3:0]  an,
    output logic        pending,
    output logic        frame
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TC_VAL = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   active;
    logic          wrap;

    logic          tc;
    logic          last;
    logic          xfer;
    logic [3:0]    nib;
    logic [3:0]    code;
    logic          z3;
    logic          z2;
    logic          z1;
    logic          blank;

    always_comb begin
        tc   = enable && (prescaler == TC_VAL);
        last = tc && (idx == 2'd3);
        xfer = pending && (last || !enable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (!enable) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (tc) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // A coincident load lands in shadow after the old shadow moved out,
    // so pending stays set for the freshly loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= 16'h0000;
            active  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (xfer) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (load) begin
                shadow  <= data;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        nib   = 4'(active >> {idx, 2'b00});
        z3    = (active[15:12] == 4'd0);
        z2    = z3 && (active[11:8] == 4'd0);
        z1    = z2 && (active[7:4] == 4'd0);
        blank = 1'b0;
        unique case (idx)
            2'd3: blank = z3;
            2'd2: blank = z2;
            2'd1: blank = z1;
            2'd0: blank = 1'b0;
        endcase
        code = (blank && blank_lz) ? 4'hF : nib;
    end

    // frame is delayed one extra cycle so it lines up with an returning to digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {W, X, Y, Z} <= 4'hF;
            an           <= 4'hF;
            wrap         <= 1'b0;
            frame        <= 1'b0;
        end else begin
            {W, X, Y, Z} <= code;
            an           <= enable ? ~(4'b0001 << idx) : 4'hF;
            wrap         <= last;
            frame        <= wrap;
        end
    end

endmodule
